// File: rtl/reg_writeback_stage_if.sv
// Write-back stage bus: execute/memory-side request and register-file-side write port.
interface reg_writeback_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned FPU_W = 64,
   parameter int unsigned RA_W  = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_src;
   logic [RA_W-1:0]  in_rd;
   logic [XLEN-1:0]  alu_res;
   logic [XLEN-1:0]  mem_read_data;
   logic [FPU_W-1:0] fpu_res;
   logic             out_valid;
   logic             out_ready;
   logic             out_we;
   logic [RA_W-1:0]  out_rd;
   logic [XLEN-1:0]  out_data;

   // Producer side: issues entries and accepts write-backs.
   modport master (
      output in_valid, in_src, in_rd, alu_res, mem_read_data, fpu_res, out_ready,
      input  in_ready, out_valid, out_we, out_rd, out_data
   );

   // Stage side.
   modport slave (
      input  in_valid, in_src, in_rd, alu_res, mem_read_data, fpu_res, out_ready,
      output in_ready, out_valid, out_we, out_rd, out_data
   );
endinterface

// File: rtl/reg_writeback_stage.sv
// Two-stage register write-back: source select, FPU fixed-point conversion
// (u32 / i32 / fp32) and x0 write suppression, with sticky status flags.
module reg_writeback_stage #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned FPU_W     = 64,
   parameter int unsigned FRAC_BITS = 15,
   parameter int unsigned RA_W      = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   reg_writeback_stage_if.slave wb,
   input  logic                 status_clear,
   output logic                 cvt_overflow,
   output logic                 illegal_src
);
   localparam int unsigned lead_w = $clog2(FPU_W);
   localparam logic [FPU_W-1:0] frac_mask = {{(FPU_W-FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}};
   localparam logic [lead_w-1:0] lead_max = lead_w'(FPU_W - 1);

   // Stage 1 state
   logic             s1_valid;
   logic [2:0]       s1_src;
   logic [RA_W-1:0]  s1_rd;
   logic [XLEN-1:0]  s1_alu;
   logic [XLEN-1:0]  s1_mem;
   logic [FPU_W-1:0] s1_fpu;

   // Stage 2 state
   logic             s2_valid;
   logic             s2_we;
   logic [RA_W-1:0]  s2_rd;
   logic [XLEN-1:0]  s2_data;

   logic ovf_q;
   logic ill_q;

   logic s2_adv;
   logic s1_adv;
   logic s1_move;

   // Conversion intermediates
   logic              fpu_neg;
   logic [FPU_W-1:0]  fpu_biased;
   logic [FPU_W-1:0]  int_part;
   logic [31:0]       u32_res;
   logic              u32_ovf;
   logic [31:0]       i32_res;
   logic              i32_ovf;
   logic [FPU_W-1:0]  mag;
   logic [lead_w-1:0] lead;
   logic [FPU_W-1:0]  norm;
   logic              round_up;
   logic [7:0]        exp_base;
   logic [30:0]       fp_body;
   logic [31:0]       fp32_res;

   logic [XLEN-1:0]   sel_data;
   logic              sel_ovf;
   logic              sel_ill;

   assign s2_adv      = !s2_valid || wb.out_ready;
   assign s1_adv      = !s1_valid || s2_adv;
   assign s1_move     = s1_valid && s2_adv;
   assign wb.in_ready = s1_adv && !reset;

   // Integer part truncated toward zero: bias negatives so the floor shift rounds up.
   always_comb begin
      fpu_neg    = s1_fpu[FPU_W-1];
      fpu_biased = fpu_neg ? (s1_fpu + frac_mask) : s1_fpu;
      int_part   = $signed(fpu_biased) >>> FRAC_BITS;
   end

   // Unsigned 32-bit saturation; (-1, 0) truncates to 0 without flagging.
   always_comb begin
      u32_res = '0;
      u32_ovf = 1'b0;
      if (fpu_neg) begin
         u32_ovf = (int_part != '0);
      end else if (int_part[FPU_W-1:32] != '0) begin
         u32_res = '1;
         u32_ovf = 1'b1;
      end else begin
         u32_res = int_part[31:0];
      end
   end

   // Signed 32-bit saturation: fits when all bits above bit 30 match the sign.
   always_comb begin
      i32_res = int_part[31:0];
      i32_ovf = 1'b0;
      if (!((&int_part[FPU_W-1:31]) || !(|int_part[FPU_W-1:31]))) begin
         i32_res = fpu_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
         i32_ovf = 1'b1;
      end
   end

   // fp32: normalise magnitude to the MSB, round to nearest even on the bits below.
   always_comb begin
      mag  = fpu_neg ? -s1_fpu : s1_fpu;
      lead = '0;
      for (int i = 0; i < FPU_W; i++) begin
         if (mag[i]) lead = lead_w'(i);
      end
      norm     = mag << (lead_max - lead);
      round_up = norm[FPU_W-25] && ((|norm[FPU_W-26:0]) || norm[FPU_W-24]);
      exp_base = 8'(lead) + 8'(127 - FRAC_BITS);
      // A carry out of the fraction bumps the exponent, which is the correct renormalisation.
      fp_body  = {exp_base, norm[FPU_W-2 -: 23]} + 31'(round_up);
      fp32_res = norm[FPU_W-1] ? {fpu_neg, fp_body} : 32'h0000_0000;
   end

   // Write-back source selection.
   always_comb begin
      sel_data = '0;
      sel_ovf  = 1'b0;
      sel_ill  = 1'b0;
      case (s1_src)
         3'b000: begin
            sel_data = XLEN'(u32_res);
            sel_ovf  = u32_ovf;
         end
         3'b001: begin
            sel_data = XLEN'(i32_res);
            sel_ovf  = i32_ovf;
         end
         3'b010: sel_data = s1_alu;
         3'b100: sel_data = s1_mem;
         3'b110: sel_data = XLEN'(fp32_res);
         default: sel_ill = 1'b1;
      endcase
   end

   // Stage 1 valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= wb.in_valid;
      end
   end

   // Stage 1 payload, captured on accept only.
   always_ff @(posedge clk) begin
      if (wb.in_valid && wb.in_ready) begin
         s1_src <= wb.in_src;
         s1_rd  <= wb.in_rd;
         s1_alu <= wb.alu_res;
         s1_mem <= wb.mem_read_data;
         s1_fpu <= wb.fpu_res;
      end
   end

   // Stage 2 holds while the register file stalls; x0 writes carry zero data.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_we    <= 1'b0;
         s2_rd    <= '0;
         s2_data  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         s2_we    <= s1_valid && (s1_rd != '0);
         if (s1_valid) begin
            s2_rd   <= s1_rd;
            s2_data <= (s1_rd == '0) ? '0 : sel_data;
         end
      end
   end

   // Sticky flags: set on stage 1 -> 2 transfer; set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q && !status_clear) || (s1_move && sel_ovf);
         ill_q <= (ill_q && !status_clear) || (s1_move && sel_ill);
      end
   end

   assign wb.out_valid = s2_valid;
   assign wb.out_we    = s2_we;
   assign wb.out_rd    = s2_rd;
   assign wb.out_data  = s2_data;
   assign cvt_overflow = ovf_q;
   assign illegal_src  = ill_q;
endmodule

// File: tb/tb_reg_writeback_stage.sv
// Scoreboard bench for reg_writeback_stage: a driver pushes reference results on
// accept, a negedge monitor pops them as entries appear on the write port.
module tb_reg_writeback_stage;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned FPU_W     = 64;
   localparam int unsigned FRAC_BITS = 15;
   localparam int unsigned RA_W      = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic status_clear = 1'b0;
   logic cvt_overflow;
   logic illegal_src;

   reg_writeback_stage_if #(.XLEN(XLEN), .FPU_W(FPU_W), .RA_W(RA_W)) wb ();

   reg_writeback_stage #(
      .XLEN(XLEN), .FPU_W(FPU_W), .FRAC_BITS(FRAC_BITS), .RA_W(RA_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wb(wb.slave),
      .status_clear(status_clear),
      .cvt_overflow(cvt_overflow),
      .illegal_src(illegal_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [RA_W-1:0] rd;
      logic [31:0]     data;
      logic            we;
      logic            ovf;
      logic            ill;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   // Nearest-even fp32 of raw / 2^FRAC_BITS, by integer division on the magnitude.
   function automatic logic [31:0] ref_fp32(input logic [63:0] raw);
      logic [63:0] mag;
      longint unsigned q, d, r, half;
      int e;
      logic s;
      if (raw == 64'd0) return 32'd0;
      s   = raw[63];
      mag = s ? (64'd0 - raw) : raw;
      e   = 0;
      while ((mag >> (e + 1)) != 64'd0) e++;
      if (e <= 23) begin
         q = mag << (23 - e);
      end else begin
         d    = 64'd1 << (e - 23);
         q    = mag / d;
         r    = mag % d;
         half = d >> 1;
         if (r > half || (r == half && (q % 2) == 1)) q++;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
         end
      end
      return {s, 8'(e + 127 - int'(FRAC_BITS)), 23'(q)};
   endfunction

   function automatic exp_t ref_model(input logic [2:0] src, input logic [RA_W-1:0] rd,
                                      input logic [31:0] alu, input logic [31:0] mem,
                                      input logic [63:0] fpu);
      longint f, ip, scale;
      logic [31:0] d;
      logic ovf, ill;
      exp_t e;
      f     = longint'(fpu);
      scale = longint'(1) << FRAC_BITS;
      ip    = f / scale;
      d     = 32'd0;
      ovf   = 1'b0;
      ill   = 1'b0;
      case (src)
         3'b000: begin
            if (ip < 0) ovf = 1'b1;
            else if (ip > 64'sd4294967295) begin d = 32'hFFFF_FFFF; ovf = 1'b1; end
            else d = 32'(ip);
         end
         3'b001: begin
            if (ip > 64'sd2147483647) begin d = 32'h7FFF_FFFF; ovf = 1'b1; end
            else if (ip < -64'sd2147483648) begin d = 32'h8000_0000; ovf = 1'b1; end
            else d = 32'(ip);
         end
         3'b010: d = alu;
         3'b100: d = mem;
         3'b110: d = ref_fp32(fpu);
         default: ill = 1'b1;
      endcase
      e.rd   = rd;
      e.data = (rd == '0) ? 32'd0 : d;
      e.we   = (rd != '0);
      e.ovf  = ovf;
      e.ill  = ill;
      return e;
   endfunction

   // Monitor state (values seen before the upcoming rising edge)
   logic            pend_reset = 1'b1;
   logic            pend_clear = 1'b0;
   logic            pend_adv = 1'b0;
   logic            pend_fire = 1'b0;
   logic            pend_acc = 1'b0;
   logic            e_ovf = 1'b0;
   logic            e_ill = 1'b0;
   int              occ = 0;
   logic [RA_W-1:0] last_rd = '0;
   logic [31:0]     last_data = '0;
   logic            last_we = 1'b0;

   always @(negedge clk) begin
      if (pend_reset) begin
         check("rst_out_valid", wb.out_valid, 0);
         check("rst_out_we", wb.out_we, 0);
         check("rst_out_rd", wb.out_rd, 0);
         check("rst_out_data", wb.out_data, 0);
         check("rst_cvt_overflow", cvt_overflow, 0);
         check("rst_illegal_src", illegal_src, 0);
         exp_q.delete();
         occ   = 0;
         e_ovf = 1'b0;
         e_ill = 1'b0;
      end else begin
         if (pend_fire) occ--;
         if (pend_acc) occ++;
         if (pend_adv && wb.out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: rd %0d data %h presented, none outstanding",
                        wb.out_rd, wb.out_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_rd", wb.out_rd, mon_e.rd);
               check("out_data", wb.out_data, mon_e.data);
               check("out_we", wb.out_we, mon_e.we);
               e_ovf = (e_ovf && !pend_clear) || mon_e.ovf;
               e_ill = (e_ill && !pend_clear) || mon_e.ill;
            end
         end else begin
            e_ovf = e_ovf && !pend_clear;
            e_ill = e_ill && !pend_clear;
            if (!pend_adv) begin
               check("hold_valid", wb.out_valid, 1);
               check("hold_rd", wb.out_rd, last_rd);
               check("hold_data", wb.out_data, last_data);
               check("hold_we", wb.out_we, last_we);
            end
         end
         check("cvt_overflow", cvt_overflow, e_ovf);
         check("illegal_src", illegal_src, e_ill);
         if (!reset) check("in_ready", wb.in_ready, (occ < 2) || wb.out_ready);
      end
      pend_reset = reset;
      pend_clear = status_clear;
      pend_adv   = !wb.out_valid || wb.out_ready;
      pend_fire  = wb.out_valid && wb.out_ready;
      pend_acc   = wb.in_valid && wb.in_ready;
      if (pend_acc) begin
         exp_q.push_back(ref_model(wb.in_src, wb.in_rd, wb.alu_res, wb.mem_read_data,
                                   wb.fpu_res));
      end
      last_rd   = wb.out_rd;
      last_data = wb.out_data;
      last_we   = wb.out_we;
   end

   // out_ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0, 3 never ready
   int or_mode = 0;
   int or_ctr = 0;
   initial begin
      wb.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            1: wb.out_ready = 1'($urandom_range(0, 1));
            2: begin
               wb.out_ready = (or_ctr % 3 == 0);
               or_ctr++;
            end
            3: wb.out_ready = 1'b0;
            default: wb.out_ready = 1'b1;
         endcase
      end
   end

   task automatic send(input logic [2:0] src, input logic [RA_W-1:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [63:0] fpu);
      logic acc;
      acc              = 1'b0;
      wb.in_valid      = 1'b1;
      wb.in_src        = src;
      wb.in_rd         = rd;
      wb.alu_res       = alu;
      wb.mem_read_data = mem;
      wb.fpu_res       = fpu;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = wb.in_ready;
         @(posedge clk);
         #1;
      end
      wb.in_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [63:0] rand_fpu();
      logic [63:0] v;
      v = {$urandom, $urandom};
      v = $signed(v) >>> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) v = v & ~64'h7FFF;
      return v;
   endfunction

   logic [2:0] legal_src [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
   logic [2:0] bad_src [3] = '{3'b011, 3'b101, 3'b111};

   initial begin
      wb.in_valid      = 1'b0;
      wb.in_src        = '0;
      wb.in_rd         = '0;
      wb.alu_res       = '0;
      wb.mem_read_data = '0;
      wb.fpu_res       = '0;
      idle(2);
      reset = 1'b0;

      // 3.0 to i32 with two-cycle latency
      send(3'b001, 5'd5, 32'd0, 32'd0, 64'h18000);
      @(negedge clk);
      check("lat_not_yet", wb.out_valid, 0);
      @(negedge clk);
      check("lat_valid", wb.out_valid, 1);
      check("lat_data", wb.out_data, 32'h0000_0003);
      check("lat_we", wb.out_we, 1);
      check("lat_ovf", cvt_overflow, 0);

      // -1.5: i32 then saturating u32, then clear
      send(3'b001, 5'd6, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_4000);
      send(3'b000, 5'd7, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_4000);
      idle(4);
      check("neg_u32_ovf", cvt_overflow, 1);
      status_clear = 1'b1;
      idle(1);
      status_clear = 1'b0;
      @(negedge clk);
      check("ovf_cleared", cvt_overflow, 0);

      // fp32 conversions
      send(3'b110, 5'd8, 32'd0, 32'd0, 64'h8000);
      send(3'b110, 5'd9, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_4000);
      idle(4);

      // i32 saturation with a clear landing on the same edge as the set
      send(3'b001, 5'd10, 32'd0, 32'd0, 64'h0080_0000_0000_0000);
      status_clear = 1'b1;
      idle(1);
      status_clear = 1'b0;
      @(negedge clk);
      check("set_beats_clear", cvt_overflow, 1);
      idle(2);

      // 8 back-to-back alu entries under a 1,0,0 ready pattern
      or_mode = 2;
      for (int i = 0; i < 8; i++) send(3'b010, RA_W'(i + 1), $urandom, 32'd0, 64'd0);
      idle(24);
      or_mode = 0;
      idle(2);

      // x0 destination and an undefined source code
      send(3'b010, 5'd0, 32'hDEAD_BEEF, 32'd0, 64'd0);
      send(3'b011, 5'd4, 32'h1234_5678, 32'h9ABC_DEF0, 64'h18000);
      idle(4);
      check("illegal_set", illegal_src, 1);

      // Reset with two entries in flight
      or_mode = 3;
      idle(2);
      send(3'b010, 5'd11, 32'h1111_1111, 32'd0, 64'd0);
      send(3'b100, 5'd12, 32'd0, 32'h2222_2222, 64'd0);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      or_mode = 0;
      @(negedge clk);
      check("post_rst_valid", wb.out_valid, 0);
      check("post_rst_in_ready", wb.in_ready, 1);
      idle(6);

      // Randomised traffic
      or_mode = 1;
      for (int i = 0; i < 300; i++) begin
         logic [2:0] src;
         if ($urandom_range(0, 7) == 0) src = bad_src[$urandom_range(0, 2)];
         else src = legal_src[$urandom_range(0, 4)];
         status_clear = ($urandom_range(0, 9) == 0);
         send(src, RA_W'($urandom), $urandom, $urandom, rand_fpu());
         status_clear = 1'b0;
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      or_mode = 0;
      idle(10);
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_occupancy", occ, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required $finish earlier", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
